sa_pe_param: RTL and testbench

SA_PE_PARAM -- requirements
Module: sa_pe_param

---
 rtl/sa_pe_param.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_sa_pe_param.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_pe_param.sv
// ---------------------------------------------------------------------------
// sa_pe_param -- parameterised systolic-array processing element
//
// One signed multiplier (act_in x operand) feeding two adders:
//   * weight-stationary (mode=0): psum_out = psum_in + act_in * active weight
//   * output-stationary (mode=1): local accumulator += act_in * psum_in[DATA_W-1:0]
// A shadow/active weight pair lets the next weight be daisy-chained in while
// the current one is in use. Adds are either saturating (SAT=1) or wrapping
// (SAT=0); any overflow sets a sticky flag cleared by rst or acc_clr.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   mode                     0 = weight-stationary, 1 = output-stationary
//   w_in, w_load, w_swap     weight load into shadow / shadow-to-active swap
//   w_out, w_load_out        weight chain to the south neighbour (1 cycle)
//   act_in, act_vld_in       activation from the west
//   act_out, act_vld_out     activation to the east (1 cycle)
//   psum_in, psum_vld_in     partial sum (WS) or operand B (OS) from the north
//   psum_out, psum_vld_out   partial sum / operand pass-through to the south
//   acc_clr, drain           output-stationary accumulator control
//   acc_out, acc_vld_out     drained accumulator value, 1-cycle valid
//   ovf                      sticky overflow flag
// ---------------------------------------------------------------------------
module sa_pe_param #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int SAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic [DATA_W-1:0] w_in,
    input  logic              w_load,
    input  logic              w_swap,
    output logic [DATA_W-1:0] w_out,
    output logic              w_load_out,
    input  logic [DATA_W-1:0] act_in,
    input  logic              act_vld_in,
    output logic [DATA_W-1:0] act_out,
    output logic              act_vld_out,
    input  logic [ACC_W-1:0]  psum_in,
    input  logic              psum_vld_in,
    output logic [ACC_W-1:0]  psum_out,
    output logic              psum_vld_out,
    input  logic              acc_clr,
    input  logic              drain,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_vld_out,
    output logic              ovf
);

    // The full signed product must fit the accumulator without loss.
    if (ACC_W < 2 * DATA_W) begin : g_bad_acc_w
        $error("sa_pe_param: ACC_W must be >= 2*DATA_W");
    end

    localparam int PROD_W = 2 * DATA_W;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    // Signed add with one guard bit. Returns {overflow, result}; the result
    // is clamped when SAT is set, otherwise the low ACC_W bits are kept.
    function automatic logic [ACC_W:0] f_add(input logic [ACC_W-1:0] a,
                                             input logic [ACC_W-1:0] b);
        logic [ACC_W:0]   sum;
        logic             of;
        logic [ACC_W-1:0] res;
        sum = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        of  = sum[ACC_W] ^ sum[ACC_W-1];
        if (of && (SAT != 0)) begin
            if (sum[ACC_W]) begin
                res = ACC_MIN;
            end else begin
                res = ACC_MAX;
            end
        end else begin
            res = sum[ACC_W-1:0];
        end
        return {of, res};
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_w_shadow;
    logic [DATA_W-1:0] r_w_active;
    logic [DATA_W-1:0] r_w_out;
    logic              r_w_load_out;
    logic [DATA_W-1:0] r_act_out;
    logic              r_act_vld_out;
    logic [ACC_W-1:0]  r_psum_out;
    logic              r_psum_vld_out;
    logic [ACC_W-1:0]  r_acc;
    logic [ACC_W-1:0]  r_acc_out;
    logic              r_acc_vld_out;
    logic              r_ovf;
    state_t            r_state;

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_opb;
    logic [PROD_W-1:0] w_act_x;
    logic [PROD_W-1:0] w_opb_x;
    logic [PROD_W-1:0] w_prod;
    logic [ACC_W-1:0]  w_prod_ext;
    logic              w_mac;
    logic [ACC_W-1:0]  w_ws_addend;
    logic [ACC_W:0]    w_ws_res;
    logic [ACC_W-1:0]  w_acc_base;
    logic [ACC_W-1:0]  w_os_addend;
    logic [ACC_W:0]    w_os_res;
    logic              w_ws_ovf;
    logic              w_os_ovf;
    logic [ACC_W-1:0]  w_acc_nxt;
    logic [ACC_W-1:0]  w_psum_nxt;
    logic              w_psum_vld_nxt;
    logic              w_ovf_nxt;
    state_t            w_state_nxt;

    // A single multiplier serves both modes; only the B operand differs.
    assign w_opb      = mode ? psum_in[DATA_W-1:0] : r_w_active;
    assign w_act_x    = PROD_W'($signed(act_in));
    assign w_opb_x    = PROD_W'($signed(w_opb));
    assign w_prod     = w_act_x * w_opb_x;
    assign w_prod_ext = ACC_W'($signed(w_prod));

    assign w_mac = mode & act_vld_in & psum_vld_in;

    // WS adder: an invalid incoming partial sum contributes zero.
    assign w_ws_addend = psum_vld_in ? psum_in : {ACC_W{1'b0}};
    assign w_ws_res    = f_add(w_ws_addend, w_prod_ext);

    // OS adder: a drain restarts accumulation from zero in the same cycle.
    assign w_os_addend = drain ? {ACC_W{1'b0}} : w_acc_base;
    assign w_os_res    = f_add(w_os_addend, w_prod_ext);

    assign w_ws_ovf = ~mode & act_vld_in & w_ws_res[ACC_W];
    assign w_os_ovf = w_mac & ~acc_clr & w_os_res[ACC_W];

    // Partial-sum path: WS computes, OS passes the operand through.
    always_comb begin
        w_psum_nxt     = r_psum_out;
        w_psum_vld_nxt = 1'b0;
        if (mode) begin
            w_psum_nxt     = psum_in;
            w_psum_vld_nxt = psum_vld_in;
        end else begin
            w_psum_vld_nxt = act_vld_in;
            if (act_vld_in) begin
                w_psum_nxt = w_ws_res[ACC_W-1:0];
            end else begin
                w_psum_nxt = r_psum_out;
            end
        end
    end

    // Accumulator next value: clear beats MAC, MAC beats plain drain.
    always_comb begin
        w_acc_nxt = r_acc;
        if (acc_clr) begin
            w_acc_nxt = {ACC_W{1'b0}};
        end else if (w_mac) begin
            w_acc_nxt = w_os_res[ACC_W-1:0];
        end else if (drain) begin
            w_acc_nxt = {ACC_W{1'b0}};
        end else begin
            w_acc_nxt = r_acc;
        end
    end

    // Sticky overflow; acc_clr wins over any overflow in the same cycle.
    always_comb begin
        w_ovf_nxt = r_ovf;
        if (acc_clr) begin
            w_ovf_nxt = 1'b0;
        end else begin
            w_ovf_nxt = r_ovf | w_ws_ovf | w_os_ovf;
        end
    end

    // ------------------------------------------------------------------
    // Accumulator control FSM
    // ------------------------------------------------------------------

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (acc_clr) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_mac) begin
                    w_state_nxt = ST_ACCUM;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (acc_clr) begin
                    w_state_nxt = ST_IDLE;
                end else if (drain && !w_mac) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: in IDLE the accumulator is known to be zero, so the
    // adder and the drain path see zero regardless of the register.
    always_comb begin
        w_acc_base = {ACC_W{1'b0}};
        case (r_state)
            ST_IDLE:  w_acc_base = {ACC_W{1'b0}};
            ST_ACCUM: w_acc_base = r_acc;
            default:  w_acc_base = {ACC_W{1'b0}};
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------

    // Weight shadow/active pair; a simultaneous load and swap moves the old
    // shadow into active while the shadow takes the new value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_w_shadow <= {DATA_W{1'b0}};
            r_w_active <= {DATA_W{1'b0}};
        end else begin
            if (w_load) begin
                r_w_shadow <= w_in;
            end
            if (w_swap) begin
                r_w_active <= r_w_shadow;
            end
        end
    end

    // One-cycle forwarding of the weight chain and the activation stream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_w_out       <= {DATA_W{1'b0}};
            r_w_load_out  <= 1'b0;
            r_act_out     <= {DATA_W{1'b0}};
            r_act_vld_out <= 1'b0;
        end else begin
            r_w_out       <= w_in;
            r_w_load_out  <= w_load;
            r_act_out     <= act_in;
            r_act_vld_out <= act_vld_in;
        end
    end

    // Partial-sum output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_psum_out     <= {ACC_W{1'b0}};
            r_psum_vld_out <= 1'b0;
        end else begin
            r_psum_out     <= w_psum_nxt;
            r_psum_vld_out <= w_psum_vld_nxt;
        end
    end

    // Accumulator, drain capture and overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc         <= {ACC_W{1'b0}};
            r_acc_out     <= {ACC_W{1'b0}};
            r_acc_vld_out <= 1'b0;
            r_ovf         <= 1'b0;
        end else begin
            r_acc         <= w_acc_nxt;
            r_acc_vld_out <= drain;
            r_ovf         <= w_ovf_nxt;
            if (drain) begin
                r_acc_out <= w_acc_base;
            end
        end
    end

    assign w_out        = r_w_out;
    assign w_load_out   = r_w_load_out;
    assign act_out      = r_act_out;
    assign act_vld_out  = r_act_vld_out;
    assign psum_out     = r_psum_out;
    assign psum_vld_out = r_psum_vld_out;
    assign acc_out      = r_acc_out;
    assign acc_vld_out  = r_acc_vld_out;
    assign ovf          = r_ovf;

endmodule

// File: tb/tb_sa_pe_param.sv
// ---------------------------------------------------------------------------
// tb_sa_pe_param -- directed self-checking bench for sa_pe_param
// (DATA_W=8, ACC_W=16, SAT=1). Inputs change 1 time unit after the rising
// edge; outputs are checked at that same point, one cycle after the stimulus.
// ---------------------------------------------------------------------------
module tb_sa_pe_param;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              mode;
    logic [DATA_W-1:0] w_in;
    logic              w_load;
    logic              w_swap;
    logic [DATA_W-1:0] w_out;
    logic              w_load_out;
    logic [DATA_W-1:0] act_in;
    logic              act_vld_in;
    logic [DATA_W-1:0] act_out;
    logic              act_vld_out;
    logic [ACC_W-1:0]  psum_in;
    logic              psum_vld_in;
    logic [ACC_W-1:0]  psum_out;
    logic              psum_vld_out;
    logic              acc_clr;
    logic              drain;
    logic [ACC_W-1:0]  acc_out;
    logic              acc_vld_out;
    logic              ovf;

    int n_checks = 0;
    int n_errors = 0;

    sa_pe_param #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .SAT    (1)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .mode         (mode),
        .w_in         (w_in),
        .w_load       (w_load),
        .w_swap       (w_swap),
        .w_out        (w_out),
        .w_load_out   (w_load_out),
        .act_in       (act_in),
        .act_vld_in   (act_vld_in),
        .act_out      (act_out),
        .act_vld_out  (act_vld_out),
        .psum_in      (psum_in),
        .psum_vld_in  (psum_vld_in),
        .psum_out     (psum_out),
        .psum_vld_out (psum_vld_out),
        .acc_clr      (acc_clr),
        .drain        (drain),
        .acc_out      (acc_out),
        .acc_vld_out  (acc_vld_out),
        .ovf          (ovf)
    );

    // 10-unit clock.
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Return every control/data input to its quiet value.
    task automatic quiet();
        w_in        = 8'd0;
        w_load      = 1'b0;
        w_swap      = 1'b0;
        act_in      = 8'd0;
        act_vld_in  = 1'b0;
        psum_in     = 16'd0;
        psum_vld_in = 1'b0;
        acc_clr     = 1'b0;
        drain       = 1'b0;
    endtask

    // Hard stop if the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst  = 1'b1;
        mode = 1'b0;
        quiet();
        #12;
        check("rst_psum_out", 32'(psum_out), 32'd0);
        check("rst_acc_vld",  32'(acc_vld_out), 32'd0);
        check("rst_ovf",      32'(ovf), 32'd0);
        rst = 1'b0;

        // ---------------- WS basic: weight 3, act -4, psum 100 -> 88
        w_load = 1'b1; w_in = 8'd3;
        tick();
        check("chain_w_out",  32'(w_out), 32'd3);
        check("chain_w_load", 32'(w_load_out), 32'd1);
        w_load = 1'b0; w_in = 8'd0; w_swap = 1'b1;
        tick();
        w_swap = 1'b0;
        act_in = 8'hFC; act_vld_in = 1'b1; psum_in = 16'd100; psum_vld_in = 1'b1;
        tick();
        check("ws_psum",      32'(psum_out), 32'd88);
        check("ws_psum_vld",  32'(psum_vld_out), 32'd1);
        check("ws_act_out",   32'(act_out), 32'hFC);
        check("ws_act_vld",   32'(act_vld_out), 32'd1);
        act_vld_in = 1'b0; psum_in = 16'd555;
        tick();
        check("ws_hold_psum", 32'(psum_out), 32'd88);
        check("ws_hold_vld",  32'(psum_vld_out), 32'd0);

        // ---------------- load + swap in the same cycle
        quiet();
        w_load = 1'b1; w_in = 8'd2;
        tick();
        w_load = 1'b0; w_swap = 1'b1;
        tick();                                   // active = 2
        w_swap = 1'b0; w_load = 1'b1; w_in = 8'd5;
        tick();                                   // shadow = 5
        w_load = 1'b1; w_in = 8'd7; w_swap = 1'b1;
        tick();                                   // active = 5, shadow = 7
        check("ls_w_out",  32'(w_out), 32'd7);
        quiet();
        act_in = 8'd1; act_vld_in = 1'b1; psum_in = 16'd1000; psum_vld_in = 1'b0;
        tick();
        check("ls_active", 32'(psum_out), 32'd5);
        quiet();
        w_swap = 1'b1;
        tick();                                   // active = 7
        quiet();
        act_in = 8'd1; act_vld_in = 1'b1;
        tick();
        check("ls_shadow", 32'(psum_out), 32'd7);

        // ---------------- OS: (2,3,-1) x (4,5,6) = 17
        quiet();
        mode = 1'b1;
        act_vld_in = 1'b1; psum_vld_in = 1'b1;
        act_in = 8'd2;  psum_in = 16'h1204;
        tick();
        check("os_pass_psum", 32'(psum_out), 32'h1204);
        check("os_pass_vld",  32'(psum_vld_out), 32'd1);
        act_in = 8'd3;  psum_in = 16'h0005;
        tick();
        act_in = 8'hFF; psum_in = 16'h0006;
        tick();
        quiet();
        drain = 1'b1;
        tick();
        check("os_drain_val", 32'(acc_out), 32'd17);
        check("os_drain_vld", 32'(acc_vld_out), 32'd1);
        drain = 1'b0;
        tick();
        check("os_vld_pulse", 32'(acc_vld_out), 32'd0);
        drain = 1'b1;
        tick();
        check("os_acc_zero",  32'(acc_out), 32'd0);
        drain = 1'b0;
        tick();

        // ---------------- drain with concurrent MAC, mode change keeps acc
        act_in = 8'd2; psum_in = 16'd5; act_vld_in = 1'b1; psum_vld_in = 1'b1;
        tick();                                   // acc = 10
        mode = 1'b0; act_in = 8'd1; psum_in = 16'd20;
        tick();                                   // WS: 20 + 1*7
        check("mode_ws_psum", 32'(psum_out), 32'd27);
        mode = 1'b1; drain = 1'b1; act_in = 8'd2; psum_in = 16'd3;
        tick();
        check("dm_acc_out",   32'(acc_out), 32'd10);
        quiet();
        tick();
        drain = 1'b1;
        tick();
        check("dm_acc_after", 32'(acc_out), 32'd6);
        quiet();

        // ---------------- saturation and acc_clr
        mode = 1'b0;
        w_load = 1'b1; w_in = 8'd1;
        tick();
        quiet(); w_swap = 1'b1;
        tick();
        check("pre_sat_ovf",  32'(ovf), 32'd0);
        quiet();
        act_in = 8'd1; act_vld_in = 1'b1; psum_in = 16'h7FFF; psum_vld_in = 1'b1;
        tick();
        check("sat_pos",      32'(psum_out), 32'h7FFF);
        check("sat_ovf",      32'(ovf), 32'd1);
        act_in = 8'hFF; psum_in = 16'h8000;
        tick();
        check("sat_neg",      32'(psum_out), 32'h8000);
        quiet();
        tick();
        check("ovf_sticky",   32'(ovf), 32'd1);
        mode = 1'b1;
        act_in = 8'd3; psum_in = 16'd4; act_vld_in = 1'b1; psum_vld_in = 1'b1;
        tick();                                   // acc = 12
        act_in = 8'd5; psum_in = 16'd5; acc_clr = 1'b1; drain = 1'b1;
        tick();                                   // MAC discarded
        check("clr_ovf",      32'(ovf), 32'd0);
        check("clr_drain",    32'(acc_out), 32'd12);
        check("clr_drain_v",  32'(acc_vld_out), 32'd1);
        quiet(); drain = 1'b1;
        tick();
        check("clr_acc_zero", 32'(acc_out), 32'd0);

        // ---------------- asynchronous reset mid-accumulation
        quiet();
        w_in = 8'd9; w_load = 1'b1;
        act_in = 8'd4; psum_in = 16'd4; act_vld_in = 1'b1; psum_vld_in = 1'b1;
        tick();                                   // acc = 16
        check("pre_rst_act",  32'(act_out), 32'd4);
        #2 rst = 1'b1;
        #1;
        check("arst_act",      32'(act_out), 32'd0);
        check("arst_act_vld",  32'(act_vld_out), 32'd0);
        check("arst_psum",     32'(psum_out), 32'd0);
        check("arst_psum_vld", 32'(psum_vld_out), 32'd0);
        check("arst_w_out",    32'(w_out), 32'd0);
        check("arst_w_load",   32'(w_load_out), 32'd0);
        check("arst_acc_out",  32'(acc_out), 32'd0);
        check("arst_acc_vld",  32'(acc_vld_out), 32'd0);
        check("arst_ovf",      32'(ovf), 32'd0);
        quiet();
        drain = 1'b1;
        #10 rst = 1'b0;
        tick();
        check("post_rst_acc", 32'(acc_out), 32'd0);
        check("post_rst_vld", 32'(acc_vld_out), 32'd1);
        quiet();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
